// File: rtl/write_submodule.sv
// Single-beat memory write engine: latches one address/data pair, drives the AW/W/B
// channels and holds the B response (or a timeout failure) for the controller.
module write_submodule #(
    parameter int unsigned ADDR_WDTH      = 4,
    parameter int unsigned DATA_WDTH      = 32,
    parameter int unsigned RESP_WDTH      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_WDTH-1:0] write_addr,
    input  logic [DATA_WDTH-1:0] write_data,
    output logic                 done,
    output logic [RESP_WDTH-1:0] resp,
    output logic                 busy,
    output logic                 aw_valid,
    input  logic                 aw_ready,
    output logic [ADDR_WDTH-1:0] aw_addr,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [DATA_WDTH-1:0] w_data,
    input  logic                 b_valid,
    input  logic [RESP_WDTH-1:0] b_resp,
    output logic                 b_ready
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSend, StWaitB, StRespHeld} state_t;

    state_t               state;
    logic                 aw_pend;
    logic                 w_pend;
    logic [CNT_W-1:0]     cnt;
    logic [ADDR_WDTH-1:0] addr_q;
    logic [DATA_WDTH-1:0] data_q;
    logic [RESP_WDTH-1:0] resp_q;
    logic                 aw_hs;
    logic                 w_hs;
    logic                 timed_out;

    // Outputs decode only registered state, so no input reaches an output combinationally.
    always_comb begin
        busy     = (state == StSend) || (state == StWaitB);
        done     = (state == StRespHeld);
        aw_valid = (state == StSend) && aw_pend;
        w_valid  = (state == StSend) && w_pend;
        b_ready  = (state == StWaitB);
        aw_addr  = addr_q;
        w_data   = data_q;
        resp     = resp_q;
    end

    always_comb begin
        aw_hs     = aw_valid && aw_ready;
        w_hs      = w_valid && w_ready;
        timed_out = (cnt == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= StIdle;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            cnt     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            resp_q  <= '0;
        end else begin
            unique case (state)
                StIdle, StRespHeld: begin
                    if (start) begin
                        addr_q  <= write_addr;
                        data_q  <= write_data;
                        aw_pend <= 1'b1;
                        w_pend  <= 1'b1;
                        cnt     <= '0;
                        state   <= StSend;
                    end
                end
                StSend: begin
                    if (timed_out) begin
                        resp_q  <= '0;
                        aw_pend <= 1'b0;
                        w_pend  <= 1'b0;
                        state   <= StRespHeld;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (aw_hs) aw_pend <= 1'b0;
                        if (w_hs) w_pend <= 1'b0;
                        if ((!aw_pend || aw_hs) && (!w_pend || w_hs)) state <= StWaitB;
                    end
                end
                StWaitB: begin
                    // A response arriving on the timeout cycle still wins.
                    if (b_valid) begin
                        resp_q <= b_resp;
                        state  <= StRespHeld;
                    end else if (timed_out) begin
                        resp_q <= '0;
                        state  <= StRespHeld;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_write_submodule.sv
// Bench for write_submodule: fixed vector table, directed corner sequences and a
// randomized run, all checked against a transaction-level model every cycle.
module tb_write_submodule;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  write_addr;
    logic [31:0] write_data;
    logic        done;
    logic [0:0]  resp;
    logic        busy;
    logic        aw_valid;
    logic        aw_ready;
    logic [3:0]  aw_addr;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic        b_valid;
    logic [0:0]  b_resp;
    logic        b_ready;

    int vectors = 0;
    int miscompares = 0;

    write_submodule #(
        .ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .write_addr(write_addr),
        .write_data(write_data), .done(done), .resp(resp), .busy(busy),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready)
    );

    always #5 clk = ~clk;

    // Transaction-level model: one outstanding write, what is still owed, and its age.
    bit          m_active, m_have, m_aw_left, m_w_left;
    int          m_age;
    logic        m_resp;
    logic [3:0]  m_addr;
    logic [31:0] m_data;

    function automatic bit e_awv(); return m_active && m_aw_left; endfunction
    function automatic bit e_wv();  return m_active && m_w_left;  endfunction
    function automatic bit e_bry(); return m_active && !m_aw_left && !m_w_left; endfunction

    task automatic model_update();
        bit aw_hs, w_hs, b_hs;
        aw_hs = e_awv() && aw_ready;
        w_hs  = e_wv() && w_ready;
        b_hs  = e_bry() && b_valid;
        if (!rst_n) begin
            m_active = 0; m_have = 0; m_aw_left = 0; m_w_left = 0;
            m_age = 0; m_resp = 0; m_addr = 0; m_data = 0;
        end else if (m_active) begin
            if (b_hs) begin
                m_resp = b_resp; m_active = 0; m_have = 1;
            end else if (m_age == TO - 1) begin
                m_resp = 0; m_active = 0; m_have = 1;
            end else begin
                m_age++;
                if (aw_hs) m_aw_left = 0;
                if (w_hs) m_w_left = 0;
            end
        end else if (start) begin
            m_addr = write_addr; m_data = write_data;
            m_active = 1; m_have = 0; m_aw_left = 1; m_w_left = 1; m_age = 0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic compare_model();
        chk("aw_valid", 32'(aw_valid), 32'(e_awv()));
        chk("w_valid", 32'(w_valid), 32'(e_wv()));
        chk("b_ready", 32'(b_ready), 32'(e_bry()));
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), 32'(!m_active && m_have));
        chk("resp", 32'(resp), 32'(m_resp));
        if (e_awv()) chk("aw_addr", 32'(aw_addr), 32'(m_addr));
        if (e_wv()) chk("w_data", w_data, m_data);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare_model();
    endtask

    task automatic quiet_inputs();
        start = 0; aw_ready = 1; w_ready = 1; b_valid = 1; b_resp = 1;
    endtask

    typedef struct {
        logic        start;
        logic [3:0]  addr;
        logic [31:0] data;
        logic        bv, br;
        logic        awv, wv, bry, dn, bsy, rsp;
        logic [3:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int n, hs, cnt_aw, cnt_bad;

        // start, addr, data, b_valid, b_resp -> aw_v, w_v, b_rdy, done, busy, resp, aw_addr, w_data
        tbl[0] = '{1, 4'h3, 32'hDEADBEEF, 1, 1, 1, 1, 0, 0, 1, 0, 4'h3, 32'hDEADBEEF};
        tbl[1] = '{0, 4'h0, 32'h0,        1, 1, 0, 0, 1, 0, 1, 0, 4'h0, 32'h0};
        tbl[2] = '{0, 4'h0, 32'h0,        1, 1, 0, 0, 0, 1, 0, 1, 4'h0, 32'h0};
        tbl[3] = '{1, 4'h5, 32'h12345678, 1, 0, 1, 1, 0, 0, 1, 1, 4'h5, 32'h12345678};
        tbl[4] = '{0, 4'hA, 32'h0,        1, 0, 0, 0, 1, 0, 1, 1, 4'h0, 32'h0};
        tbl[5] = '{0, 4'hA, 32'h0,        1, 0, 0, 0, 0, 1, 0, 0, 4'h0, 32'h0};
        tbl[6] = '{1, 4'h6, 32'hCAFEF00D, 1, 1, 1, 1, 0, 0, 1, 0, 4'h6, 32'hCAFEF00D};
        tbl[7] = '{0, 4'h0, 32'h0,        1, 1, 0, 0, 1, 0, 1, 0, 4'h0, 32'h0};
        tbl[8] = '{0, 4'h0, 32'h0,        1, 1, 0, 0, 0, 1, 0, 1, 4'h0, 32'h0};

        quiet_inputs();
        write_addr = 0; write_data = 0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        chk("reset_done", 32'(done), 0);
        chk("reset_busy", 32'(busy), 0);

        // Zero-wait and error-response vectors
        foreach (tbl[i]) begin
            start = tbl[i].start; write_addr = tbl[i].addr; write_data = tbl[i].data;
            aw_ready = 1; w_ready = 1; b_valid = tbl[i].bv; b_resp = tbl[i].br;
            tick();
            chk($sformatf("tbl%0d_awv", i), 32'(aw_valid), 32'(tbl[i].awv));
            chk($sformatf("tbl%0d_wv", i), 32'(w_valid), 32'(tbl[i].wv));
            chk($sformatf("tbl%0d_brdy", i), 32'(b_ready), 32'(tbl[i].bry));
            chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].dn));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("tbl%0d_resp", i), 32'(resp), 32'(tbl[i].rsp));
            if (tbl[i].awv) begin
                chk($sformatf("tbl%0d_addr", i), 32'(aw_addr), 32'(tbl[i].e_addr));
                chk($sformatf("tbl%0d_data", i), w_data, tbl[i].e_data);
            end
        end

        // Skewed: AW accepted 4 cycles late, W at once
        quiet_inputs(); start = 1; write_addr = 4'h7; write_data = 32'h0BADF00D; aw_ready = 0;
        tick();
        start = 0; cnt_aw = 0; cnt_bad = 0;
        for (int i = 0; i < 5; i++) begin
            aw_ready = (i == 4);
            if (aw_valid) cnt_aw++;
            if (b_ready) cnt_bad++;
            if (i == 1) chk("skew_w_dropped", 32'(w_valid), 0);
            tick();
        end
        chk("skew_aw_cycles", 32'(cnt_aw), 5);
        chk("skew_bready_early", 32'(cnt_bad), 0);
        chk("skew_bready_after", 32'(b_ready), 1);
        tick();
        chk("skew_done", 32'(done), 1);

        // Timeout: memory never responds
        quiet_inputs(); b_valid = 0; start = 1; write_addr = 4'h2;
        tick();
        start = 0; n = 1;
        while (!done && n < 20) begin tick(); n++; end
        chk("timeout_latency", 32'(n), TO + 1);
        chk("timeout_resp", 32'(resp), 0);
        chk("timeout_bready", 32'(b_ready), 0);
        tick();
        chk("timeout_bready_after", 32'(b_ready), 0);

        // Start while busy is ignored
        quiet_inputs(); start = 1; write_addr = 4'h1; write_data = 32'h11111111;
        tick();
        write_addr = 4'h9; write_data = 32'h99999999; aw_ready = 0;
        hs = 0; n = 0;
        while (!done && n < 20) begin
            if (n == 2) begin start = 0; aw_ready = 1; end
            if (aw_valid && aw_ready) begin
                hs++;
                chk("busy_start_addr", 32'(aw_addr), 32'h1);
            end
            tick(); n++;
        end
        chk("busy_start_handshakes", 32'(hs), 1);
        chk("busy_start_done", 32'(done), 1);

        // Reset during SEND abandons the write
        quiet_inputs(); start = 1; write_addr = 4'hC; aw_ready = 0; w_ready = 0;
        tick();
        start = 0; rst_n = 0;
        tick();
        rst_n = 1;
        chk("rst_aw_valid", 32'(aw_valid), 0);
        chk("rst_w_valid", 32'(w_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        quiet_inputs(); start = 1; write_addr = 4'hD; write_data = 32'hFEEDFACE;
        tick();
        start = 0; n = 1;
        while (!done && n < 20) begin tick(); n++; end
        chk("rst_fresh_latency", 32'(n), 3);
        chk("rst_fresh_resp", 32'(resp), 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 2) == 0);
            write_addr = 4'($urandom); write_data = $urandom;
            aw_ready = $urandom_range(0, 1) != 0;
            w_ready = $urandom_range(0, 1) != 0;
            b_valid = ($urandom_range(0, 3) == 0);
            b_resp = 1'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
